pipe_alu: RTL

PIPE_ALU -- requirements
Module: pipe_alu

---
 rtl/alu_pkg.sv | 17 +
 rtl/carry_add.sv | 23 ++
 rtl/pipe_alu.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-stage pipelined ALU: operation encoding and
// condition-code bit positions within {ZF,SF,OF}.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  localparam int unsigned CC_W  = 3;
  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

endpackage

// File: rtl/carry_add.sv
// N-bit ripple-carry adder with carry-in and carry-out; used once per operand half.
module carry_add #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin : p_ripple
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipe_alu.sv
// Two-stage pipelined ALU: stage 1 resolves the low half and its carry, stage 2
// finishes the high half and flags; valid/ready on both sides plus a cc register.
module pipe_alu
  import alu_pkg::*;
#(
  parameter int unsigned W        = 64,
  parameter logic [2:0]  CC_RESET = 3'b100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_set_cc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [2:0]   out_cc,
  output logic [2:0]   cc_q
);

  localparam int unsigned H = W / 2;

  if (((W % 2) != 0) || (W < 4)) begin : g_bad_width
    $error("pipe_alu: W must be even and at least 4");
  end

  // Stage 1 combinational: low-half arithmetic, SUB folded in as a + ~b + 1
  alu_op_e       op_in;
  logic          sub_in;
  logic [H-1:0]  b_lo_eff;
  logic [H-1:0]  b_hi_eff;
  logic [H-1:0]  lo_sum;
  logic [H-1:0]  lo_res;
  logic          lo_cout;

  assign op_in    = alu_op_e'(in_op);
  assign sub_in   = (op_in == ALU_SUB);
  assign b_lo_eff = sub_in ? ~in_b[H-1:0] : in_b[H-1:0];
  assign b_hi_eff = sub_in ? ~in_b[W-1:H] : in_b[W-1:H];

  carry_add #(.N(H)) u_add_lo (
    .a    (in_a[H-1:0]),
    .b    (b_lo_eff),
    .cin  (sub_in),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  always_comb begin : p_lo_result
    lo_res = lo_sum;
    if (op_in == ALU_AND) begin
      lo_res = in_a[H-1:0] & in_b[H-1:0];
    end else if (op_in == ALU_XOR) begin
      lo_res = in_a[H-1:0] ^ in_b[H-1:0];
    end
  end

  // Stage 1 registers
  logic          s1_valid_q,  s1_valid_d;
  logic [H-1:0]  s1_lo_q,     s1_lo_d;
  logic          s1_carry_q,  s1_carry_d;
  logic [H-1:0]  s1_a_hi_q,   s1_a_hi_d;
  logic [H-1:0]  s1_b_hi_q,   s1_b_hi_d;
  alu_op_e       s1_op_q,     s1_op_d;
  logic          s1_set_cc_q, s1_set_cc_d;

  // Stage 2 combinational: high half from registered carry, then flags
  logic [H-1:0]  hi_sum;
  logic          hi_cout;
  logic [H-1:0]  hi_res;
  logic [W-1:0]  res_c;
  logic [2:0]    cc_c;

  carry_add #(.N(H)) u_add_hi (
    .a    (s1_a_hi_q),
    .b    (s1_b_hi_q),
    .cin  (s1_carry_q),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_comb begin : p_hi_result
    hi_res = hi_sum;
    if (s1_op_q == ALU_AND) begin
      hi_res = s1_a_hi_q & s1_b_hi_q;
    end else if (s1_op_q == ALU_XOR) begin
      hi_res = s1_a_hi_q ^ s1_b_hi_q;
    end
    res_c        = {hi_res, s1_lo_q};
    cc_c         = '0;
    cc_c[CC_ZF]  = (res_c == '0);
    cc_c[CC_SF]  = res_c[W-1];
    // Signed overflow = carry into MSB differs from carry out of MSB
    if ((s1_op_q == ALU_ADD) || (s1_op_q == ALU_SUB)) begin
      cc_c[CC_OF] = hi_cout ^ (hi_sum[H-1] ^ s1_a_hi_q[H-1] ^ s1_b_hi_q[H-1]);
    end
  end

  // Stage 2 registers
  logic          out_valid_q,  out_valid_d;
  logic [W-1:0]  out_result_q, out_result_d;
  logic [2:0]    out_cc_q,     out_cc_d;
  logic          out_set_cc_q, out_set_cc_d;
  logic [2:0]    cc_d;

  logic s1_adv;
  logic in_fire;
  logic out_fire;

  assign s1_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin : p_next
    s1_valid_d   = s1_valid_q;
    s1_lo_d      = s1_lo_q;
    s1_carry_d   = s1_carry_q;
    s1_a_hi_d    = s1_a_hi_q;
    s1_b_hi_d    = s1_b_hi_q;
    s1_op_d      = s1_op_q;
    s1_set_cc_d  = s1_set_cc_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_cc_d     = out_cc_q;
    out_set_cc_d = out_set_cc_q;
    cc_d         = cc_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_fire) begin
      s1_lo_d     = lo_res;
      s1_carry_d  = lo_cout;
      s1_a_hi_d   = in_a[W-1:H];
      s1_b_hi_d   = ((op_in == ALU_ADD) || sub_in) ? b_hi_eff : in_b[W-1:H];
      s1_op_d     = op_in;
      s1_set_cc_d = in_set_cc;
    end

    if (s1_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_result_d = res_c;
        out_cc_d     = cc_c;
        out_set_cc_d = s1_set_cc_q;
      end
    end

    if (out_fire && out_set_cc_q) begin
      cc_d = out_cc_q;
    end
  end

  always_ff @(posedge clk) begin : p_regs
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_lo_q      <= '0;
      s1_carry_q   <= 1'b0;
      s1_a_hi_q    <= '0;
      s1_b_hi_q    <= '0;
      s1_op_q      <= ALU_ADD;
      s1_set_cc_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_cc_q     <= '0;
      out_set_cc_q <= 1'b0;
      cc_q         <= CC_RESET;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_lo_q      <= s1_lo_d;
      s1_carry_q   <= s1_carry_d;
      s1_a_hi_q    <= s1_a_hi_d;
      s1_b_hi_q    <= s1_b_hi_d;
      s1_op_q      <= s1_op_d;
      s1_set_cc_q  <= s1_set_cc_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_cc_q     <= out_cc_d;
      out_set_cc_q <= out_set_cc_d;
      cc_q         <= cc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_cc     = out_cc_q;

endmodule
